// File: rtl/iob_pfsm_loader_pkg.sv
// Shared types and sizing helpers for the PFSM LUT loader.
// The sizing formulas match the ones the PFSM itself uses.
package iob_pfsm_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RST_ON  = 3'd1,
      ST_SEL     = 3'd2,
      ST_FETCH   = 3'd3,
      ST_WR_MEM  = 3'd4,
      ST_RST_OFF = 3'd5,
      ST_DONE    = 3'd6
   } state_t;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   function automatic int calc_n_words(input int state_w, input int output_w, input int data_w);
      return ceil_div(state_w + output_w, data_w);
   endfunction

   function automatic int calc_depth(input int state_w, input int input_w);
      return 1 << (state_w + input_w);
   endfunction

   function automatic int calc_n_bytes(input int data_w);
      return ceil_div(data_w, 8);
   endfunction

endpackage

// File: rtl/iob_pfsm_loader_req.sv
// IOb write request holding register: loads a request when idle, holds it
// until the subordinate accepts, then drops avalid and the strobes.
module iob_pfsm_loader_req
   import iob_pfsm_loader_pkg::*;
#(
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 32,
   parameter int N_BYTES = 4
) (
   input  logic               clk_i,
   input  logic               cke_i,
   input  logic               arst_i,
   input  logic               load_i,
   input  logic [ADDR_W-1:0]  addr_i,
   input  logic [DATA_W-1:0]  wdata_i,
   input  logic               ready_i,
   output logic               avalid_o,
   output logic [ADDR_W-1:0]  addr_o,
   output logic [DATA_W-1:0]  wdata_o,
   output logic [N_BYTES-1:0] wstrb_o,
   output logic               accept_o
);

   logic               avalid_q, avalid_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [N_BYTES-1:0] wstrb_q, wstrb_d;

   assign accept_o = avalid_q & ready_i;

   always_comb begin
      avalid_d = avalid_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      if (accept_o) begin
         avalid_d = 1'b0;
         wstrb_d  = '0;
      end else if (load_i && !avalid_q) begin
         avalid_d = 1'b1;
         addr_d   = addr_i;
         wdata_d  = wdata_i;
         wstrb_d  = '1;
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         avalid_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
      end else if (cke_i) begin
         avalid_q <= avalid_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
      end
   end

   assign avalid_o = avalid_q;
   assign addr_o   = addr_q;
   assign wdata_o  = wdata_q;
   assign wstrb_o  = wstrb_q;

endmodule

// File: rtl/iob_pfsm_loader.sv
// Programs a PFSM LUT over its IOb CSR port from a word stream:
// SOFTRESET=1, then per LUT word a MEM_WORD_SELECT write and DEPTH entries, then SOFTRESET=0.
module iob_pfsm_loader
   import iob_pfsm_loader_pkg::*;
#(
   parameter int DATA_W               = 32,
   parameter int ADDR_W               = 6,
   parameter int STATE_W              = 2,
   parameter int INPUT_W              = 1,
   parameter int OUTPUT_W             = 1,
   parameter int SOFTRESET_ADDR       = 0,
   parameter int MEM_WORD_SELECT_ADDR = 4,
   parameter int MEMORY_ADDR          = 32
) (
   input  logic                    clk_i,
   input  logic                    cke_i,
   input  logic                    arst_i,
   input  logic                    start_i,
   output logic                    busy_o,
   output logic                    done_o,
   input  logic                    s_valid_i,
   input  logic [DATA_W-1:0]       s_data_i,
   output logic                    s_ready_o,
   output logic                    iob_avalid_o,
   output logic [ADDR_W-1:0]       iob_addr_o,
   output logic [DATA_W-1:0]       iob_wdata_o,
   output logic [(DATA_W+7)/8-1:0] iob_wstrb_o,
   input  logic                    iob_rvalid_i,
   input  logic [DATA_W-1:0]       iob_rdata_i,
   input  logic                    iob_ready_i
);

   localparam int N_WORDS = calc_n_words(STATE_W, OUTPUT_W, DATA_W);
   localparam int DEPTH   = calc_depth(STATE_W, INPUT_W);
   localparam int N_BYTES = calc_n_bytes(DATA_W);
   localparam int A_W     = STATE_W + INPUT_W;
   localparam int W_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

   localparam logic [A_W-1:0] A_LAST = A_W'(DEPTH - 1);
   localparam logic [W_W-1:0] W_LAST = W_W'(N_WORDS - 1);

   if (MEMORY_ADDR + DEPTH * N_BYTES > (1 << ADDR_W)) begin : g_addr_overflow
      $error("iob_pfsm_loader: LUT window does not fit in ADDR_W address bits");
   end

   // Write-only initiator: the read response channel is intentionally dropped.
   logic unused_iob_rd;
   assign unused_iob_rd = ^{iob_rvalid_i, iob_rdata_i};

   state_t          state_q, state_d;
   logic [A_W-1:0]  a_q, a_d;
   logic [W_W-1:0]  w_q, w_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            s_ready_q, s_ready_d;

   logic              req_ld;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              accept;
   logic [ADDR_W-1:0] mem_addr;

   assign mem_addr = ADDR_W'(MEMORY_ADDR) + ADDR_W'(a_q) * ADDR_W'(N_BYTES);

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      w_d       = w_q;
      req_ld    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_RST_ON;
               a_d     = '0;
               w_d     = '0;
            end
         end
         ST_RST_ON: begin
            req_ld    = 1'b1;
            req_addr  = ADDR_W'(SOFTRESET_ADDR);
            req_wdata = DATA_W'(1);
            if (accept) state_d = ST_SEL;
         end
         ST_SEL: begin
            req_ld    = 1'b1;
            req_addr  = ADDR_W'(MEM_WORD_SELECT_ADDR);
            req_wdata = DATA_W'(w_q);
            if (accept) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            // The beat goes straight into the request register; WR_MEM only waits for accept.
            if (s_valid_i && s_ready_q) begin
               req_ld    = 1'b1;
               req_addr  = mem_addr;
               req_wdata = s_data_i;
               state_d   = ST_WR_MEM;
            end
         end
         ST_WR_MEM: begin
            if (accept) begin
               if (a_q != A_LAST) begin
                  a_d     = a_q + 1'b1;
                  state_d = ST_FETCH;
               end else if (w_q != W_LAST) begin
                  a_d     = '0;
                  w_d     = w_q + 1'b1;
                  state_d = ST_SEL;
               end else begin
                  state_d = ST_RST_OFF;
               end
            end
         end
         ST_RST_OFF: begin
            req_ld    = 1'b1;
            req_addr  = ADDR_W'(SOFTRESET_ADDR);
            req_wdata = '0;
            if (accept) state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d    = (state_d == ST_DONE);
      s_ready_d = (state_d == ST_FETCH);
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         w_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         s_ready_q <= 1'b0;
      end else if (cke_i) begin
         state_q   <= state_d;
         a_q       <= a_d;
         w_q       <= w_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         s_ready_q <= s_ready_d;
      end
   end

   iob_pfsm_loader_req #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .N_BYTES(N_BYTES)
   ) u_req (
      .clk_i   (clk_i),
      .cke_i   (cke_i),
      .arst_i  (arst_i),
      .load_i  (req_ld),
      .addr_i  (req_addr),
      .wdata_i (req_wdata),
      .ready_i (iob_ready_i),
      .avalid_o(iob_avalid_o),
      .addr_o  (iob_addr_o),
      .wdata_o (iob_wdata_o),
      .wstrb_o (iob_wstrb_o),
      .accept_o(accept)
   );

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign s_ready_o = s_ready_q;

endmodule
